// File: rtl/sdf_fft_stage.sv
// Radix-2 DIF single-path-delay-feedback FFT stage for N = 2**STAGE_LOG2 points.
// Optional macro BFLY_SCALE_EN: butterfly outputs are halved (round-half-up) so the stage cannot overflow.
module sdf_fft_stage #(
  parameter int STAGE_LOG2 = 4,
  parameter int DW         = 32,
  parameter int TW_W       = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_in,
  input  logic          end_in,
  input  logic [DW-1:0] din_real,
  input  logic [DW-1:0] din_img,
  output logic [DW-1:0] dout_real,
  output logic [DW-1:0] dout_img,
  output logic          start_out,
  output logic          end_out
);

  localparam int N  = 1 << STAGE_LOG2;
  localparam int H  = N / 2;
  localparam int TI = (STAGE_LOG2 > 1) ? STAGE_LOG2 - 1 : 1;
  localparam int PW = DW + TW_W;
  localparam real PI = 3.14159265358979323846;

  // Elaboration-time twiddle: round(cos) or round(-sin) scaled to Q1.(TW_W-2), clamped to TW_W.
  function automatic logic signed [TW_W-1:0] tw_calc(input int idx, input bit imag);
    real    ang;
    real    v;
    longint r;
    longint lim;
    ang = 2.0 * PI * real'(idx) / real'(N);
    v   = (imag ? -$sin(ang) : $cos(ang)) * real'(longint'(1) << (TW_W - 2));
    r   = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
    lim = (longint'(1) << (TW_W - 1)) - 1;
    if (r > lim)      r = lim;
    if (r < -lim - 1) r = -lim - 1;
    return TW_W'(r);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                  state;
  logic [STAGE_LOG2-1:0]   cnt;
  logic [STAGE_LOG2-1:0]   fcnt;
  logic [STAGE_LOG2-1:0]   cur_cnt;
  logic                    run_like;
  logic                    active;
  logic                    phase;
  logic                    pend;

  logic signed [DW-1:0]    dl_re [H];
  logic signed [DW-1:0]    dl_im [H];
  logic signed [DW-1:0]    c_re, c_im, a_re, a_im;
  logic signed [DW-1:0]    sum_re, sum_im, dif_re, dif_im;
  logic signed [DW-1:0]    bf_re, bf_im, dly_re, dly_im;
  logic                    bf_valid, bf_start, bf_end;
  logic [TI-1:0]           tw_idx;

  logic signed [DW-1:0]    b_re, b_im;
  logic                    b_valid, b_start, b_end;
  logic [TI-1:0]           b_idx;
  logic signed [TW_W-1:0]  w_re, w_im;

  logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir;
  logic                    m_valid, m_start, m_end;

  logic signed [TW_W-1:0]  rom_re [H];
  logic signed [TW_W-1:0]  rom_im [H];

  for (genvar i = 0; i < H; i++) begin : g_rom
    localparam logic signed [TW_W-1:0] RE = tw_calc(i, 1'b0);
    localparam logic signed [TW_W-1:0] IM = tw_calc(i, 1'b1);
    assign rom_re[i] = RE;
    assign rom_im[i] = IM;
  end

  // A start_in forces the current sample to count 0, so frames may follow each other or resync.
  always_comb begin
    cur_cnt  = start_in ? '0 : cnt;
    run_like = start_in || (state == RUN);
    active   = start_in || (state != IDLE);
    phase    = cur_cnt[STAGE_LOG2-1];
    c_re     = dl_re[H-1];
    c_im     = dl_im[H-1];
    a_re     = run_like ? din_real : '0;
    a_im     = run_like ? din_img  : '0;
`ifdef BFLY_SCALE_EN
    sum_re   = DW'(((DW+1)'(c_re) + (DW+1)'(a_re) + (DW+1)'(1)) >>> 1);
    sum_im   = DW'(((DW+1)'(c_im) + (DW+1)'(a_im) + (DW+1)'(1)) >>> 1);
    dif_re   = DW'(((DW+1)'(c_re) - (DW+1)'(a_re) + (DW+1)'(1)) >>> 1);
    dif_im   = DW'(((DW+1)'(c_im) - (DW+1)'(a_im) + (DW+1)'(1)) >>> 1);
`else
    sum_re   = c_re + a_re;
    sum_im   = c_im + a_im;
    dif_re   = c_re - a_re;
    dif_im   = c_im - a_im;
`endif
    if (phase) begin
      bf_re  = sum_re;
      bf_im  = sum_im;
      dly_re = dif_re;
      dly_im = dif_im;
    end else begin
      bf_re  = c_re;
      bf_im  = c_im;
      dly_re = a_re;
      dly_im = a_im;
    end
    bf_valid = phase ? run_like : (active && pend);
    bf_start = run_like && (cur_cnt == STAGE_LOG2'(H));
    bf_end   = (state == FLUSH) && !start_in && !phase && pend && (fcnt == STAGE_LOG2'(H - 1));
    tw_idx   = phase ? '0 : TI'(cur_cnt);
  end

  assign w_re = rom_re[b_idx];
  assign w_im = rom_im[b_idx];

  // pend marks that the delay line holds a half-frame of differences still to be emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      fcnt  <= '0;
      pend  <= 1'b0;
    end else begin
      cnt <= active ? cur_cnt + STAGE_LOG2'(1) : '0;
      if (active) begin
        if (run_like && cur_cnt == STAGE_LOG2'(N - 1))
          pend <= 1'b1;
        else if (cur_cnt == STAGE_LOG2'(H - 1))
          pend <= 1'b0;
      end
      if (run_like && end_in) begin
        state <= FLUSH;
        fcnt  <= '0;
      end else if (start_in) begin
        state <= RUN;
      end else if (state == FLUSH) begin
        if (fcnt == STAGE_LOG2'(H - 1))
          state <= IDLE;
        fcnt <= fcnt + STAGE_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < H; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
      b_re      <= '0;
      b_im      <= '0;
      b_valid   <= 1'b0;
      b_start   <= 1'b0;
      b_end     <= 1'b0;
      b_idx     <= '0;
      p_rr      <= '0;
      p_ii      <= '0;
      p_ri      <= '0;
      p_ir      <= '0;
      m_valid   <= 1'b0;
      m_start   <= 1'b0;
      m_end     <= 1'b0;
      dout_real <= '0;
      dout_img  <= '0;
      start_out <= 1'b0;
      end_out   <= 1'b0;
    end else begin
      dl_re[0] <= dly_re;
      dl_im[0] <= dly_im;
      for (int i = 1; i < H; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
      b_re    <= bf_re;
      b_im    <= bf_im;
      b_valid <= bf_valid;
      b_start <= bf_start;
      b_end   <= bf_end;
      b_idx   <= tw_idx;
      p_rr    <= PW'(b_re) * PW'(w_re);
      p_ii    <= PW'(b_im) * PW'(w_im);
      p_ri    <= PW'(b_re) * PW'(w_im);
      p_ir    <= PW'(b_im) * PW'(w_re);
      m_valid <= b_valid;
      m_start <= b_start;
      m_end   <= b_end;
      // Full-precision product, truncating shift back to Q0, then wrap to DW.
      dout_real <= m_valid ? DW'(((PW+1)'(p_rr) - (PW+1)'(p_ii)) >>> (TW_W - 2)) : '0;
      dout_img  <= m_valid ? DW'(((PW+1)'(p_ri) + (PW+1)'(p_ir)) >>> (TW_W - 2)) : '0;
      start_out <= m_valid && m_start;
      end_out   <= m_valid && m_end;
    end
  end

endmodule

// File: tb/tb_sdf_fft_stage.sv
// Scoreboard bench for sdf_fft_stage (N=16): reference DIF butterfly + twiddle model with timed expectations.
module tb_sdf_fft_stage;

  localparam int STAGE_LOG2 = 4;
  localparam int N          = 16;
  localparam int H          = 8;
  localparam int DW         = 32;
  localparam int TW_W       = 18;
  localparam int TW_SHIFT   = TW_W - 2;
  localparam int LAT        = H + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic          end_in;
  logic [DW-1:0] din_real;
  logic [DW-1:0] din_img;
  logic [DW-1:0] dout_real;
  logic [DW-1:0] dout_img;
  logic          start_out;
  logic          end_out;

  sdf_fft_stage #(.STAGE_LOG2(STAGE_LOG2), .DW(DW), .TW_W(TW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .end_in    (end_in),
    .din_real  (din_real),
    .din_img   (din_img),
    .dout_real (dout_real),
    .dout_img  (dout_img),
    .start_out (start_out),
    .end_out   (end_out)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint        at;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          st;
    logic          en;
  } exp_t;

  exp_t                 sb[$];
  exp_t                 mon_e;
  logic signed [DW-1:0] xr[$];
  logic signed [DW-1:0] xi[$];
  int                   checks = 0;
  int                   errors = 0;
  bit                   mon_en = 1'b0;

  function automatic longint tw(input int n, input bit imag);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(n) / real'(N);
    v   = (imag ? -$sin(ang) : $cos(ang)) * real'(longint'(1) << TW_SHIFT);
    return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  // Monitor: a scheduled result must appear exactly on its cycle; otherwise outputs must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].at <= cyc) begin
        mon_e = sb.pop_front();
        check_output("dout_real", dout_real, mon_e.re);
        check_output("dout_img", dout_img, mon_e.im);
        check_output("start_out", DW'(start_out), DW'(mon_e.st));
        check_output("end_out", DW'(end_out), DW'(mon_e.en));
      end else begin
        check_output("idle_real", dout_real, '0);
        check_output("idle_img", dout_img, '0);
        check_output("idle_start", DW'(start_out), '0);
        check_output("idle_end", DW'(end_out), '0);
      end
    end
  end

  // Reference: per frame, sums x[n]+x[n+N/2] then differences times W^n, in output order.
  task automatic push_expected(input longint t0, input int nframes);
    logic signed [DW-1:0] ar, ai, br, bi, sr, si, dr, di;
    logic signed [DW-1:0] d_re [H];
    logic signed [DW-1:0] d_im [H];
    longint               pr, pi;
    exp_t                 e;
    for (int f = 0; f < nframes; f++) begin
      for (int n = 0; n < H; n++) begin
        ar = xr[f*N + n];
        ai = xi[f*N + n];
        br = xr[f*N + n + H];
        bi = xi[f*N + n + H];
`ifdef BFLY_SCALE_EN
        sr = DW'((longint'(ar) + longint'(br) + 1) >>> 1);
        si = DW'((longint'(ai) + longint'(bi) + 1) >>> 1);
        dr = DW'((longint'(ar) - longint'(br) + 1) >>> 1);
        di = DW'((longint'(ai) - longint'(bi) + 1) >>> 1);
`else
        sr = ar + br;
        si = ai + bi;
        dr = ar - br;
        di = ai - bi;
`endif
        pr = (longint'(dr) * tw(n, 1'b0) - longint'(di) * tw(n, 1'b1)) >>> TW_SHIFT;
        pi = (longint'(dr) * tw(n, 1'b1) + longint'(di) * tw(n, 1'b0)) >>> TW_SHIFT;
        d_re[n] = DW'(pr);
        d_im[n] = DW'(pi);
        e.at = t0 + longint'(f*N + LAT + n);
        e.re = sr;
        e.im = si;
        e.st = (n == 0);
        e.en = 1'b0;
        sb.push_back(e);
      end
      for (int n = 0; n < H; n++) begin
        e.at = t0 + longint'(f*N + LAT + H + n);
        e.re = d_re[n];
        e.im = d_im[n];
        e.st = 1'b0;
        e.en = (f == nframes - 1) && (n == H - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic make_frame(input int kind, input int pos);
    logic signed [DW-1:0] r, i;
    for (int n = 0; n < N; n++) begin
      r = '0;
      i = '0;
      case (kind)
        0: r = (n == pos) ? 1000 : 0;
        1: r = 1000;
        2: begin r = $urandom(); i = $urandom(); end
        3: begin r = int'($urandom_range(4000)) - 2000; i = int'($urandom_range(4000)) - 2000; end
        default: r = (n == 0 || n == H) ? 32'h7FFF_FFFF : 0;
      endcase
      xr.push_back(r);
      xi.push_back(i);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int nframes);
    longint t0;
    @(posedge clk);
    #1;
    t0 = cyc;
    push_expected(t0, nframes);
    for (int i = 0; i < nframes*N; i++) begin
      start_in = (i % N == 0);
      end_in   = (i == nframes*N - 1);
      din_real = xr[i];
      din_img  = xi[i];
      @(posedge clk);
      #1;
    end
    start_in = 1'b0;
    end_in   = 1'b0;
    din_real = '0;
    din_img  = '0;
    xr.delete();
    xi.delete();
    drain();
  endtask

  task automatic reset_mid_frame();
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      start_in = (i == 0);
      din_real = $urandom();
      din_img  = $urandom();
      @(posedge clk);
      #1;
    end
    start_in = 1'b0;
    din_real = '0;
    din_img  = '0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    start_in = 1'b0;
    end_in   = 1'b0;
    din_real = '0;
    din_img  = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    make_frame(0, 0);  apply_stimulus(1);
    make_frame(1, 0);  apply_stimulus(1);
    make_frame(0, 8);  apply_stimulus(1);
    make_frame(0, 1);  apply_stimulus(1);
    make_frame(1, 0);  make_frame(0, 0); apply_stimulus(2);
    reset_mid_frame();
    make_frame(0, 0);  apply_stimulus(1);
    for (int f = 0; f < 3; f++) make_frame(2, 0);
    apply_stimulus(3);
    for (int f = 0; f < 4; f++) make_frame(3, 0);
    apply_stimulus(4);
    make_frame(4, 0);  apply_stimulus(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
